lsu_mem_initiator: RTL and testbench
====================================

Name: lsu_mem_initiator

Overview:
- Load/store initiator that drives one port of the byte-addressable 32-bit data RAM on behalf of the core pipeline.
- Accepts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW):
  - generates the byte-lane mask and lane-shifted store data;
  - issues one RAM access per request;
  - captures the fixed one-cycle read return;
  - returns sign- or zero-extended load data.
- Flags misaligned or illegal accesses without touching memory.
- Sits between the execute stage and the RAM port.

Parameters:
DEPTH, 8192, RAM depth in 32-bit words; must match the attached RAM.
ADDR_W, $clog2(DEPTH)+2, byte-address width driven to the RAM (15 by default).

Ports:
clk  in  1  single clock; all state on rising edge.
rstf  in  1  reset, asynchronous, active-high.
t_req_valid  in  1  core request valid.
t_req_ready  out  1  request accepted when valid&ready.
t_req_we  in  1  1=store, 0=load.
t_req_funct3  in  3  RV32I width/sign code (0 B, 1 H, 2 W, 4 BU, 5 HU).
t_req_addr  in  32  byte address.
t_req_wdata  in  32  store data, right-justified.
t_req_rd  in  5  destination register tag, echoed on response.
i_rsp_valid  out  1  response valid.
i_rsp_ready  in  1  response consumed when valid&ready.
i_rsp_data  out  32  extended load data; 0 for stores and errors.
i_rsp_rd  out  5  echoed tag.
i_rsp_err  out  1  misaligned or illegal funct3.
i_mem_valid  out  1  RAM request valid.
i_mem_ready  in  1  RAM request ready.
i_mem_we  out  1  RAM write enable.
i_mem_addr  out  ADDR_W  RAM byte address (t_req_addr[ADDR_W-1:0]).
i_mem_data  out  32  lane-aligned store data.
i_mem_mask  out  4  byte-lane write mask.
t_mem_valid  in  1  RAM read data valid.
t_mem_ready  out  1  tied 1.
t_mem_data  in  32  RAM read data.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - state=IDLE;
  - t_req_ready=0 while rstf is high;
  - i_rsp_valid=0, i_mem_valid=0, i_mem_we=0, i_mem_mask=0;
  - i_rsp_data=0, i_rsp_rd=0, i_rsp_err=0, i_mem_addr=0, i_mem_data=0.
- States: IDLE, REQ, WAIT, RESP. Exactly one request in flight.
- IDLE:
  - t_req_ready=1.
  - On acceptance, register addr/we/funct3/wdata/rd.
  - Error check: funct3 in {3,6,7} is illegal; H/HU with addr[0]!=0 is misaligned; W with addr[1:0]!=0 is misaligned.
  - Error -> RESP with err=1, data=0, no RAM access.
  - Otherwise -> REQ.
- REQ:
  - i_mem_valid=1, holding addr/we/data/mask stable until i_mem_ready.
  - On handshake: load -> WAIT; store -> RESP (err=0, data=0).
- Store lane rules, off = addr[1:0]:
  - SB: mask=4'b0001<<off, data={4{wdata[7:0]}}.
  - SH: mask=4'b0011<<off, data={2{wdata[15:0]}}.
  - SW: mask=4'b1111, data=wdata.
- Loads drive mask=0, we=0.
- WAIT:
  - t_mem_data is captured on the first cycle t_mem_valid=1; RAM read latency is 1 cycle after the handshake.
  - Extraction: byte = t_mem_data[8*off+:8]; half = t_mem_data[16*addr[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - -> RESP.
- RESP:
  - i_rsp_valid=1, outputs held stable until i_rsp_ready.
  - Then -> IDLE. No same-cycle re-accept; t_req_ready rises the cycle after.
- Latency, load, accept at T:
  - i_mem_valid at T+1 (ready=1);
  - data returns at T+2;
  - i_rsp_valid at T+3.
- Latency, store: i_rsp_valid at T+2.
- Latency, error: i_rsp_valid at T+1.
- Boundaries:
  - t_mem_valid outside WAIT is ignored.
  - Address bits [31:ADDR_W] are ignored; the address wraps modulo RAM size.
  - A reset asserted in any state aborts to IDLE. A RAM read returning after reset deasserts is ignored.
  - A store interrupted in REQ may or may not have been written.

Test Plan:
- Reset: rstf pulse mid-WAIT -> all outputs 0 immediately; the stale t_mem_valid next cycle produces no response.
- SW addr 0x10, wdata 0xDEADBEEF -> i_mem_mask=1111, i_mem_addr=0x10, data 0xDEADBEEF; rsp at T+2, data 0, err 0.
- SB addr 0x13, wdata 0x000000A5 -> mask=1000, data 0xA5A5A5A5.
- LB addr 0x13 with RAM word 0xA5000000 -> rsp 0xFFFFFFA5 at T+3. LBU same address -> 0x000000A5.
- LH addr 0x12 with RAM word 0x8001xxxx -> 0xFFFF8001. LW addr 0x12 -> err=1, rsp at T+1, no i_mem_valid pulse.
- Backpressure: i_mem_ready low 3 cycles, then i_rsp_ready low 2 cycles -> request fields stable throughout, exactly one response, t_req_ready low until the response is consumed. Check tag rd=7 is echoed.

Source files
------------

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: RV32I load/store initiator for one data RAM port.
// One request in flight; lane masking on stores, extension on loads.
module lsu_mem_initiator #(
  parameter int DEPTH  = 8192,
  parameter int ADDR_W = $clog2(DEPTH) + 2
) (
  input  logic              clk,
  input  logic              rstf,
  input  logic              t_req_valid,
  output logic              t_req_ready,
  input  logic              t_req_we,
  input  logic [2:0]        t_req_funct3,
  input  logic [31:0]       t_req_addr,
  input  logic [31:0]       t_req_wdata,
  input  logic [4:0]        t_req_rd,
  output logic              i_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       i_rsp_data,
  output logic [4:0]        i_rsp_rd,
  output logic              i_rsp_err,
  output logic              i_mem_valid,
  input  logic              i_mem_ready,
  output logic              i_mem_we,
  output logic [ADDR_W-1:0] i_mem_addr,
  output logic [31:0]       i_mem_data,
  output logic [3:0]        i_mem_mask,
  input  logic              t_mem_valid,
  output logic              t_mem_ready,
  input  logic [31:0]       t_mem_data
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;
  logic [31:0]       data_q;
  logic              err_q;

  logic              illegal;
  logic              misal;
  logic              bad;
  logic [1:0]        off;
  logic [3:0]        mask_w;
  logic [31:0]       data_w;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_data;
  logic              in_req;
  logic              in_resp;
  logic              unused_addr;

  // Upper address bits wrap away; the RAM only sees ADDR_W bits.
  assign unused_addr = ^t_req_addr[31:ADDR_W];

  assign off     = addr_q[1:0];
  assign in_req  = (state == REQ);
  assign in_resp = (state == RESP);

  // Classify the incoming request: bad width code or misaligned address.
  always_comb begin
    illegal = 1'b0;
    misal   = 1'b0;
    unique case (t_req_funct3)
      3'd3, 3'd6, 3'd7: illegal = 1'b1;
      3'd1, 3'd5:       misal = t_req_addr[0];
      3'd2:             misal = |t_req_addr[1:0];
      default:          misal = 1'b0;
    endcase
    bad = illegal | misal;
  end

  // Store lane mask and replicated data from the captured request.
  always_comb begin
    mask_w = 4'b1111;
    data_w = wdata_q;
    unique case (f3_q[1:0])
      2'd0: begin
        mask_w = 4'b0001 << off;
        data_w = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        mask_w = 4'b0011 << off;
        data_w = {2{wdata_q[15:0]}};
      end
      default: begin
        mask_w = 4'b1111;
        data_w = wdata_q;
      end
    endcase
  end

  // Pick the addressed byte/half from the returned word and extend it.
  always_comb begin
    ld_byte = 8'h00;
    unique case (off)
      2'd0: ld_byte = t_mem_data[7:0];
      2'd1: ld_byte = t_mem_data[15:8];
      2'd2: ld_byte = t_mem_data[23:16];
      default: ld_byte = t_mem_data[31:24];
    endcase
    ld_half = addr_q[1] ? t_mem_data[31:16] : t_mem_data[15:0];
    unique case (f3_q)
      3'd0: ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1: ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4: ld_data = {24'h0, ld_byte};
      3'd5: ld_data = {16'h0, ld_half};
      default: ld_data = t_mem_data;
    endcase
  end

  // Next-state logic for the single-outstanding request sequencer.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (t_req_valid) state_nx = bad ? RESP : REQ;
      REQ: if (i_mem_ready) state_nx = we_q ? RESP : WAIT;
      WAIT: if (t_mem_valid) state_nx = RESP;
      RESP: if (i_rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register; reset aborts any access in progress.
  always_ff @(posedge clk or posedge rstf) begin
    if (rstf) state <= IDLE;
    else      state <= state_nx;
  end

  // Capture request fields on accept and load data on return.
  always_ff @(posedge clk or posedge rstf) begin
    if (rstf) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      wdata_q <= 32'h0;
      rd_q    <= 5'd0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (t_req_valid) begin
          addr_q  <= t_req_addr[ADDR_W-1:0];
          we_q    <= t_req_we;
          f3_q    <= t_req_funct3;
          wdata_q <= t_req_wdata;
          rd_q    <= t_req_rd;
          data_q  <= 32'h0;
          err_q   <= bad;
        end
        WAIT: if (t_mem_valid) data_q <= ld_data;
        default: ;
      endcase
    end
  end

  assign t_req_ready = (state == IDLE) & ~rstf;
  assign t_mem_ready = 1'b1;

  assign i_mem_valid = in_req;
  assign i_mem_we    = in_req & we_q;
  assign i_mem_addr  = in_req ? addr_q : '0;
  assign i_mem_data  = (in_req & we_q) ? data_w : 32'h0;
  assign i_mem_mask  = (in_req & we_q) ? mask_w : 4'h0;

  assign i_rsp_valid = in_resp;
  assign i_rsp_data  = in_resp ? data_q : 32'h0;
  assign i_rsp_rd    = in_resp ? rd_q : 5'd0;
  assign i_rsp_err   = in_resp & err_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb_lsu_mem_initiator: directed checks of lsu_mem_initiator.
// Linear stimulus with hand-computed expected values.
module tb_lsu_mem_initiator;

  localparam int ADDR_W = 15;

  logic              clk = 1'b0;
  logic              rstf;
  logic              t_req_valid;
  logic              t_req_ready;
  logic              t_req_we;
  logic [2:0]        t_req_funct3;
  logic [31:0]       t_req_addr;
  logic [31:0]       t_req_wdata;
  logic [4:0]        t_req_rd;
  logic              i_rsp_valid;
  logic              i_rsp_ready;
  logic [31:0]       i_rsp_data;
  logic [4:0]        i_rsp_rd;
  logic              i_rsp_err;
  logic              i_mem_valid;
  logic              i_mem_ready;
  logic              i_mem_we;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [31:0]       i_mem_data;
  logic [3:0]        i_mem_mask;
  logic              t_mem_valid;
  logic              t_mem_ready;
  logic [31:0]       t_mem_data;

  int vectors = 0;
  int miscompares = 0;

  lsu_mem_initiator dut (
    .clk(clk),
    .rstf(rstf),
    .t_req_valid(t_req_valid),
    .t_req_ready(t_req_ready),
    .t_req_we(t_req_we),
    .t_req_funct3(t_req_funct3),
    .t_req_addr(t_req_addr),
    .t_req_wdata(t_req_wdata),
    .t_req_rd(t_req_rd),
    .i_rsp_valid(i_rsp_valid),
    .i_rsp_ready(i_rsp_ready),
    .i_rsp_data(i_rsp_data),
    .i_rsp_rd(i_rsp_rd),
    .i_rsp_err(i_rsp_err),
    .i_mem_valid(i_mem_valid),
    .i_mem_ready(i_mem_ready),
    .i_mem_we(i_mem_we),
    .i_mem_addr(i_mem_addr),
    .i_mem_data(i_mem_data),
    .i_mem_mask(i_mem_mask),
    .t_mem_valid(t_mem_valid),
    .t_mem_ready(t_mem_ready),
    .t_mem_data(t_mem_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; returns just after the accept edge.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd);
    t_req_valid  = 1'b1;
    t_req_we     = we;
    t_req_funct3 = f3;
    t_req_addr   = addr;
    t_req_wdata  = wd;
    t_req_rd     = rd;
    #1;
    chk("req_ready", 32'(t_req_ready), 32'd1);
    cyc();
    t_req_valid = 1'b0;
  endtask

  // Run a load from WAIT: return word, then check the response.
  task automatic load_rsp(input string tag, input logic [31:0] word,
                          input logic [31:0] exp, input logic [4:0] rd);
    #1;
    chk({tag, "_mvalid"}, 32'(i_mem_valid), 32'd1);
    chk({tag, "_mmask"}, 32'(i_mem_mask), 32'h0);
    cyc();
    t_mem_valid = 1'b1;
    t_mem_data  = word;
    #1;
    chk({tag, "_early"}, 32'(i_rsp_valid), 32'd0);
    cyc();
    t_mem_valid = 1'b0;
    t_mem_data  = 32'h0;
    #1;
    chk({tag, "_rvalid"}, 32'(i_rsp_valid), 32'd1);
    chk({tag, "_data"}, i_rsp_data, exp);
    chk({tag, "_rd"}, 32'(i_rsp_rd), 32'(rd));
    chk({tag, "_err"}, 32'(i_rsp_err), 32'd0);
    cyc();
  endtask

  initial begin
    rstf         = 1'b1;
    t_req_valid  = 1'b0;
    t_req_we     = 1'b0;
    t_req_funct3 = 3'd0;
    t_req_addr   = 32'h0;
    t_req_wdata  = 32'h0;
    t_req_rd     = 5'd0;
    i_rsp_ready  = 1'b1;
    i_mem_ready  = 1'b1;
    t_mem_valid  = 1'b0;
    t_mem_data   = 32'h0;
    cyc();
    cyc();
    chk("rst_req_ready", 32'(t_req_ready), 32'd0);
    chk("rst_mem_valid", 32'(i_mem_valid), 32'd0);
    chk("rst_rsp_valid", 32'(i_rsp_valid), 32'd0);
    chk("rst_mem_mask", 32'(i_mem_mask), 32'd0);
    chk("rst_mem_addr", 32'(i_mem_addr), 32'd0);
    chk("rst_t_mem_ready", 32'(t_mem_ready), 32'd1);
    rstf = 1'b0;
    cyc();

    // SW 0x10
    issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 5'd1);
    #1;
    chk("sw_mvalid", 32'(i_mem_valid), 32'd1);
    chk("sw_we", 32'(i_mem_we), 32'd1);
    chk("sw_mask", 32'(i_mem_mask), 32'hF);
    chk("sw_addr", 32'(i_mem_addr), 32'h10);
    chk("sw_data", i_mem_data, 32'hDEADBEEF);
    chk("sw_early", 32'(i_rsp_valid), 32'd0);
    cyc();
    #1;
    chk("sw_rvalid", 32'(i_rsp_valid), 32'd1);
    chk("sw_rdata", i_rsp_data, 32'h0);
    chk("sw_err", 32'(i_rsp_err), 32'd0);
    chk("sw_rd", 32'(i_rsp_rd), 32'd1);
    chk("sw_busy", 32'(t_req_ready), 32'd0);
    cyc();
    #1;
    chk("sw_idle", 32'(i_rsp_valid), 32'd0);

    // SB 0x13
    issue(1'b1, 3'd0, 32'h13, 32'h000000A5, 5'd2);
    #1;
    chk("sb_mask", 32'(i_mem_mask), 32'h8);
    chk("sb_data", i_mem_data, 32'hA5A5A5A5);
    chk("sb_addr", 32'(i_mem_addr), 32'h13);
    cyc();
    #1;
    chk("sb_rvalid", 32'(i_rsp_valid), 32'd1);
    cyc();

    // Address wraps modulo RAM size
    issue(1'b1, 3'd2, 32'hFFFF8010, 32'h01234567, 5'd4);
    #1;
    chk("wrap_addr", 32'(i_mem_addr), 32'h10);
    cyc();
    cyc();

    // Loads with sign and zero extension
    issue(1'b0, 3'd0, 32'h13, 32'h0, 5'd3);
    load_rsp("lb", 32'hA5000000, 32'hFFFFFFA5, 5'd3);
    issue(1'b0, 3'd4, 32'h13, 32'h0, 5'd3);
    load_rsp("lbu", 32'hA5000000, 32'h000000A5, 5'd3);
    issue(1'b0, 3'd1, 32'h12, 32'h0, 5'd6);
    load_rsp("lh", 32'h80011234, 32'hFFFF8001, 5'd6);
    issue(1'b0, 3'd5, 32'h12, 32'h0, 5'd6);
    load_rsp("lhu", 32'h80011234, 32'h00008001, 5'd6);
    issue(1'b0, 3'd2, 32'h20, 32'h0, 5'd9);
    load_rsp("lw", 32'hCAFEF00D, 32'hCAFEF00D, 5'd9);

    // Misaligned LW: immediate error, no RAM access
    issue(1'b0, 3'd2, 32'h12, 32'h0, 5'd8);
    #1;
    chk("lwmis_rvalid", 32'(i_rsp_valid), 32'd1);
    chk("lwmis_err", 32'(i_rsp_err), 32'd1);
    chk("lwmis_data", i_rsp_data, 32'h0);
    chk("lwmis_mvalid", 32'(i_mem_valid), 32'd0);
    cyc();
    #1;
    chk("lwmis_mvalid2", 32'(i_mem_valid), 32'd0);
    chk("lwmis_idle", 32'(t_req_ready), 32'd1);

    // Illegal funct3
    issue(1'b1, 3'd3, 32'h0, 32'h0, 5'd10);
    #1;
    chk("ill_err", 32'(i_rsp_err), 32'd1);
    chk("ill_mvalid", 32'(i_mem_valid), 32'd0);
    cyc();

    // Backpressure on both RAM and response sides
    i_mem_ready = 1'b0;
    issue(1'b1, 3'd1, 32'h22, 32'h0000BEEF, 5'd7);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_mvalid", 32'(i_mem_valid), 32'd1);
      chk("bp_mask", 32'(i_mem_mask), 32'hC);
      chk("bp_data", i_mem_data, 32'hBEEFBEEF);
      chk("bp_addr", 32'(i_mem_addr), 32'h22);
      chk("bp_busy", 32'(t_req_ready), 32'd0);
      cyc();
    end
    i_mem_ready = 1'b1;
    i_rsp_ready = 1'b0;
    #1;
    chk("bp_mvalid_last", 32'(i_mem_valid), 32'd1);
    cyc();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("bp_rvalid", 32'(i_rsp_valid), 32'd1);
      chk("bp_rd", 32'(i_rsp_rd), 32'd7);
      chk("bp_err", 32'(i_rsp_err), 32'd0);
      chk("bp_rbusy", 32'(t_req_ready), 32'd0);
      chk("bp_mvalid_off", 32'(i_mem_valid), 32'd0);
      cyc();
    end
    i_rsp_ready = 1'b1;
    #1;
    chk("bp_rvalid_hold", 32'(i_rsp_valid), 32'd1);
    chk("bp_rd_hold", 32'(i_rsp_rd), 32'd7);
    cyc();
    #1;
    chk("bp_done", 32'(i_rsp_valid), 32'd0);
    chk("bp_ready", 32'(t_req_ready), 32'd1);

    // Reset in WAIT, then a stale read return
    issue(1'b0, 3'd2, 32'h20, 32'h0, 5'd5);
    cyc();
    rstf = 1'b1;
    #1;
    chk("rw_req_ready", 32'(t_req_ready), 32'd0);
    chk("rw_mvalid", 32'(i_mem_valid), 32'd0);
    chk("rw_rvalid", 32'(i_rsp_valid), 32'd0);
    chk("rw_rdata", i_rsp_data, 32'h0);
    cyc();
    rstf = 1'b0;
    t_mem_valid = 1'b1;
    t_mem_data  = 32'h12345678;
    #1;
    chk("rw_idle", 32'(t_req_ready), 32'd1);
    cyc();
    t_mem_valid = 1'b0;
    t_mem_data  = 32'h0;
    #1;
    chk("rw_norsp1", 32'(i_rsp_valid), 32'd0);
    cyc();
    #1;
    chk("rw_norsp2", 32'(i_rsp_valid), 32'd0);
    chk("rw_ready2", 32'(t_req_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
